// File: rtl/keyb_fifo.sv
// keyb_fifo: PS/2 scancode FIFO with an 8042-style data/status register pair
// on a Wishbone slave port and a one-cycle interrupt pulse per readable byte.
module keyb_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  scan_dat_i,
  input  logic        scan_vld_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_tgc_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [7:0] CMD_DISABLE = 8'hAD;
  localparam logic [7:0] CMD_ENABLE  = 8'hAE;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [CW-1:0]         count;
  logic [7:0]            out_reg;
  logic                  obf;
  logic                  ovr;
  logic                  en;

  // Attributes of the bus request captured at the strobe edge, applied at ack end
  logic                  req_adr;
  logic                  req_we;
  logic                  req_obf;
  logic [7:0]            req_cmd;

  logic                  wb_req_c;
  logic [7:0]            status_c;
  logic [7:0]            cmd_c;
  logic                  cmd_done_c;
  logic                  rd_data_done_c;
  logic                  rd_stat_done_c;
  logic                  en_nxt_c;
  logic                  full_c;
  logic                  push_c;
  logic                  drop_c;
  logic                  load_c;
  logic                  unused_sel_c;

  // Request decode, command handling and FIFO push/load qualification
  always_comb begin
    wb_req_c       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    status_c       = {ovr, 2'b00, 1'b1, 3'b000, obf};
    cmd_c          = wb_sel_i[0] ? wb_dat_i[7:0] : wb_dat_i[15:8];
    unused_sel_c   = wb_sel_i[1];
    cmd_done_c     = wb_ack_o & req_we & req_adr;
    rd_data_done_c = wb_ack_o & ~req_we & ~req_adr & req_obf;
    rd_stat_done_c = wb_ack_o & ~req_we & req_adr;
    // A command completing this edge is already visible to a push on the same edge
    en_nxt_c       = en;
    if (cmd_done_c) begin
      if (req_cmd == CMD_DISABLE) begin
        en_nxt_c = 1'b0;
      end else if (req_cmd == CMD_ENABLE) begin
        en_nxt_c = 1'b1;
      end
    end
    full_c = (count == CW'(DEPTH));
    push_c = scan_vld_i & en_nxt_c & ~full_c;
    drop_c = scan_vld_i & en_nxt_c & full_c;
    // Load only from the queue; a byte entering an empty FIFO waits one cycle
    load_c = ~obf & (count != '0);
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge wb_clk_i) begin
    if (push_c) begin
      mem[wr_ptr] <= scan_dat_i;
    end
  end

  // FIFO pointers, occupancy and output register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_reg <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (load_c) begin
        out_reg <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({push_c, load_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status flags and interrupt pulse; set beats clear on ovr
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      obf      <= 1'b0;
      ovr      <= 1'b0;
      en       <= 1'b1;
      wb_tgc_o <= 1'b0;
    end else begin
      en       <= en_nxt_c;
      wb_tgc_o <= load_c;
      if (load_c) begin
        obf <= 1'b1;
      end else if (rd_data_done_c) begin
        obf <= 1'b0;
      end
      if (drop_c) begin
        ovr <= 1'b1;
      end else if (rd_stat_done_c) begin
        ovr <= 1'b0;
      end
    end
  end

  // Wishbone slave: one ack per request, read data and request capture
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      req_adr  <= 1'b0;
      req_we   <= 1'b0;
      req_obf  <= 1'b0;
      req_cmd  <= '0;
    end else begin
      wb_ack_o <= wb_req_c;
      if (wb_req_c) begin
        req_adr <= wb_adr_i;
        req_we  <= wb_we_i;
        req_obf <= obf;
        req_cmd <= cmd_c;
        if (!wb_we_i) begin
          wb_dat_o <= wb_adr_i ? {status_c, status_c} : {out_reg, out_reg};
        end
      end
    end
  end

endmodule

// File: tb/tb_keyb_fifo.sv
// tb_keyb_fifo: directed stimulus with a scoreboard queue of expected read data
// checked by an independent monitor on every acknowledge.
module tb_keyb_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  scan_dat = '0;
  logic        scan_vld = 1'b0;
  logic        wb_adr = 1'b0;
  logic [15:0] wb_dat_w = '0;
  logic [15:0] wb_dat_r;
  logic [1:0]  wb_sel = 2'b11;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack;
  logic        wb_tgc;

  typedef struct {
    logic        chk;
    logic [15:0] d;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   tgc_cnt = 0;
  logic ack_prev = 1'b0;

  always #5 clk = ~clk;

  keyb_fifo #(.DEPTH_LOG2(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .scan_dat_i (scan_dat),
    .scan_vld_i (scan_vld),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_w),
    .wb_dat_o   (wb_dat_r),
    .wb_sel_i   (wb_sel),
    .wb_we_i    (wb_we),
    .wb_stb_i   (wb_stb),
    .wb_cyc_i   (wb_cyc),
    .wb_ack_o   (wb_ack),
    .wb_tgc_o   (wb_tgc)
  );

  // Monitor: pops the scoreboard on each ack and checks ack is one cycle wide
  always @(negedge clk) begin
    if (wb_tgc) tgc_cnt++;
    if (wb_ack) begin
      checks++;
      if (ack_prev) begin
        errors++;
        $display("FAIL ack_width: ack high on consecutive cycles, required single cycle");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack with no outstanding request");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (wb_dat_r !== mon_e.d) begin
            errors++;
            $display("FAIL %s: got %h required %h", mon_e.nm, wb_dat_r, mon_e.d);
          end
        end
      end
    end
    ack_prev = wb_ack;
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // One Wishbone access; returns just after the edge that ends the ack cycle
  task automatic bus(input logic adr, input logic we, input logic [15:0] d,
                     input logic [1:0] sel, input logic c, input logic [15:0] ed,
                     input string nm);
    exp_t e;
    int   n;
    e.chk = c;
    e.d   = ed;
    e.nm  = nm;
    exp_q.push_back(e);
    @(negedge clk);
    wb_adr   = adr;
    wb_we    = we;
    wb_dat_w = d;
    wb_sel   = sel;
    wb_stb   = 1'b1;
    wb_cyc   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_ack && n < 10);
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    if (!wb_ack) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ack within 10 cycles", nm);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
  endtask

  task automatic rd(input logic adr, input logic [15:0] ed, input string nm);
    bus(adr, 1'b0, 16'h0000, 2'b11, 1'b1, ed, nm);
  endtask

  task automatic wr_cmd(input logic [7:0] cmd);
    bus(1'b1, 1'b1, {8'h00, cmd}, 2'b01, 1'b0, 16'h0000, "cmd");
  endtask

  // Push n incrementing bytes on consecutive cycles starting at first
  task automatic push_seq(input logic [7:0] first, input int n);
    @(negedge clk);
    scan_vld = 1'b1;
    for (int i = 0; i < n; i++) begin
      scan_dat = first + 8'(i);
      @(negedge clk);
    end
    scan_vld = 1'b0;
  endtask

  initial begin
    int          base;
    logic [7:0]  b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ack", 16'(wb_ack), 16'h0000);
    chk("reset_tgc", 16'(wb_tgc), 16'h0000);
    chk("reset_dat", wb_dat_r, 16'h0000);
    rd(1'b1, 16'h1010, "reset_status");
    chk("reset_no_tgc", 16'(tgc_cnt), 16'h0000);

    // Single byte: interrupt exactly two edges after the push strobe
    base = tgc_cnt;
    push_seq(8'h1C, 1);
    chk("single_tgc_early", 16'(wb_tgc), 16'h0000);
    @(negedge clk);
    chk("single_tgc_pulse", 16'(wb_tgc), 16'h0001);
    @(negedge clk);
    chk("single_tgc_end", 16'(wb_tgc), 16'h0000);
    rd(1'b1, 16'h1111, "single_status_obf");
    rd(1'b0, 16'h1C1C, "single_data");
    rd(1'b1, 16'h1010, "single_status_after");
    chk("single_tgc_count", 16'(tgc_cnt - base), 16'h0001);

    // Burst of five bytes drained in order
    base = tgc_cnt;
    push_seq(8'h01, 5);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      b = 8'h01 + 8'(i);
      rd(1'b0, {b, b}, "burst_data");
      repeat (2) @(negedge clk);
    end
    rd(1'b1, 16'h1010, "burst_status");
    chk("burst_tgc_count", 16'(tgc_cnt - base), 16'h0005);

    // Overrun: 18 bytes, out_reg plus 16 queued survive, last one lost
    push_seq(8'h20, 18);
    repeat (3) @(negedge clk);
    rd(1'b1, 16'h9191, "ovr_status");
    rd(1'b1, 16'h1111, "ovr_cleared");
    for (int i = 0; i < 17; i++) begin
      repeat (2) @(negedge clk);
      b = 8'h20 + 8'(i);
      rd(1'b0, {b, b}, "ovr_drain");
    end
    repeat (3) @(negedge clk);
    rd(1'b1, 16'h1010, "ovr_final");

    // Disable drops silently, enable resumes delivery
    base = tgc_cnt;
    wr_cmd(8'hAD);
    push_seq(8'h55, 1);
    repeat (3) @(negedge clk);
    rd(1'b1, 16'h1010, "dis_status");
    wr_cmd(8'hAE);
    push_seq(8'h66, 1);
    repeat (3) @(negedge clk);
    rd(1'b1, 16'h1111, "en_status");
    rd(1'b0, 16'h6666, "en_data");
    repeat (3) @(negedge clk);
    rd(1'b1, 16'h1010, "en_final");
    chk("en_tgc_count", 16'(tgc_cnt - base), 16'h0001);

    // Push on the same edge as a reload keeps order
    base = tgc_cnt;
    push_seq(8'hA1, 2);
    repeat (3) @(negedge clk);
    rd(1'b0, 16'hA1A1, "sim_data0");
    push_seq(8'hA3, 1);
    repeat (3) @(negedge clk);
    rd(1'b0, 16'hA2A2, "sim_data1");
    repeat (3) @(negedge clk);
    rd(1'b0, 16'hA3A3, "sim_data2");
    repeat (3) @(negedge clk);
    rd(1'b1, 16'h1010, "sim_status");
    chk("sim_tgc_count", 16'(tgc_cnt - base), 16'h0003);

    // Reset mid-operation clears the pending byte
    push_seq(8'h77, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tgc", 16'(wb_tgc), 16'h0000);
    chk("rst_mid_dat", wb_dat_r, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(1'b1, 16'h1010, "rst_mid_status");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
